// File: rtl/baud_rate_gen_param_if.sv
// ---------------------------------------------------------------------------
// baud_rate_gen_param_if
//
// Purpose : divisor-programming bus for baud_rate_gen_param. A master issues
//           a one-cycle write strobe with a new divisor value. The generator
//           answers one cycle later with an accept (div_ack) or a reject
//           (div_err) pulse.
//
// Signals :
//   div_wr    master -> slave  one-cycle divisor write strobe
//   div_data  master -> slave  new divisor value (DIV_W bits)
//   div_frac  master -> slave  fractional divisor, sixteenths of a clock
//                              (present only when BAUD_FRAC_DIV_EN is defined)
//   div_ack   slave -> master  one-cycle pulse, write accepted
//   div_err   slave -> master  one-cycle pulse, write rejected
//
// Build option : BAUD_FRAC_DIV_EN adds the div_frac signal.
// ---------------------------------------------------------------------------
interface baud_rate_gen_param_if #(
  parameter int DIV_W = 16
);

  logic             div_wr;
  logic [DIV_W-1:0] div_data;
`ifdef BAUD_FRAC_DIV_EN
  logic [3:0]       div_frac;
`endif
  logic             div_ack;
  logic             div_err;

`ifdef BAUD_FRAC_DIV_EN
  modport master (output div_wr, div_data, div_frac, input div_ack, div_err);
  modport slave  (input div_wr, div_data, div_frac, output div_ack, div_err);
`else
  modport master (output div_wr, div_data, input div_ack, div_err);
  modport slave  (input div_wr, div_data, output div_ack, div_err);
`endif

endinterface

// File: rtl/baud_rate_gen_param.sv
// ---------------------------------------------------------------------------
// baud_rate_gen_param
//
// Purpose : runtime-programmable baud tick generator for the UART blocks.
//           A single divisor drives two independent prescalers:
//             - rx path: an OVERSAMPLE-x tick (o_rx_en) plus a mid-bit strobe
//               (o_rx_mid). The phase can be realigned to a start-bit edge
//               with i_rx_restart.
//             - tx path: a 1x bit tick (o_tx_en) that a receive realignment
//               never disturbs.
//           The rx tick period is div_q+1 clocks. The tx bit period is
//           (div_q+1)*OVERSAMPLE clocks.
//
// Ports   :
//   i_clk         system clock
//   i_rst         synchronous, active-high reset
//   i_en          count enable; when low, every counter holds
//   i_rx_restart  realign the rx phase (start-bit edge detected)
//   div_if        divisor write bus (slave side): div_wr/div_data[/div_frac]
//                 in, div_ack/div_err out
//   o_rx_en       one-cycle receive oversample tick
//   o_rx_mid      one-cycle pulse on the rx tick at mid-bit
//   o_tx_en       one-cycle transmit bit tick
//
// Build option : BAUD_FRAC_DIV_EN enables the fractional divisor. Each path
//                gets a 4-bit accumulator. A carry-out stretches that path's
//                next tick period by one clock.
// ---------------------------------------------------------------------------
module baud_rate_gen_param #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 163,
  parameter int OVERSAMPLE  = 16,
  parameter int OS_W        = 6,
  parameter int MIN_DIV     = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_rx_restart,
  baud_rate_gen_param_if.slave  div_if,
  output logic                  o_rx_en,
  output logic                  o_rx_mid,
  output logic                  o_tx_en
);

  localparam logic [DIV_W-1:0] DIV_RST   = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DIV_MIN   = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_MID_M1 = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_ONE    = OS_W'(1);

  logic [DIV_W-1:0] r_div_q;
  logic             r_div_ack;
  logic             r_div_err;

  logic [DIV_W-1:0] r_rx_cnt;
  logic [OS_W-1:0]  r_rx_os;
  logic             r_rx_en;
  logic             r_rx_mid;

  logic [DIV_W-1:0] r_tx_cnt;
  logic [OS_W-1:0]  r_tx_os;
  logic             r_tx_en;

  logic             w_wr_ok;
  logic [DIV_W:0]   w_rx_limit;
  logic [DIV_W:0]   w_tx_limit;
  logic             w_rx_hit;
  logic             w_tx_hit;
  logic [OS_W-1:0]  w_rx_os_next;
  logic [OS_W-1:0]  w_tx_os_next;

`ifdef BAUD_FRAC_DIV_EN
  logic [3:0]       r_frac_q;
  logic [3:0]       r_rx_acc;
  logic [3:0]       r_tx_acc;
  logic             r_rx_extra;
  logic             r_tx_extra;
  logic [4:0]       w_rx_acc_sum;
  logic [4:0]       w_tx_acc_sum;
`endif

  // A write is accepted only when the requested divisor is large enough.
  assign w_wr_ok = div_if.div_wr && (div_if.div_data >= DIV_MIN);

  // Terminal counts. The limits are one bit wider than the divisor so that
  // the fractional "+1" stretch cannot wrap a maximal divisor.
`ifdef BAUD_FRAC_DIV_EN
  assign w_rx_acc_sum = {1'b0, r_rx_acc} + {1'b0, r_frac_q};
  assign w_tx_acc_sum = {1'b0, r_tx_acc} + {1'b0, r_frac_q};
  assign w_rx_limit   = {1'b0, r_div_q} + {{DIV_W{1'b0}}, r_rx_extra};
  assign w_tx_limit   = {1'b0, r_div_q} + {{DIV_W{1'b0}}, r_tx_extra};
`else
  assign w_rx_limit   = {1'b0, r_div_q};
  assign w_tx_limit   = {1'b0, r_div_q};
`endif

  assign w_rx_hit     = ({1'b0, r_rx_cnt} == w_rx_limit);
  assign w_tx_hit     = ({1'b0, r_tx_cnt} == w_tx_limit);
  assign w_rx_os_next = (r_rx_os == OS_LAST) ? '0 : r_rx_os + OS_ONE;
  assign w_tx_os_next = (r_tx_os == OS_LAST) ? '0 : r_tx_os + OS_ONE;

  assign div_if.div_ack = r_div_ack;
  assign div_if.div_err = r_div_err;
  assign o_rx_en        = r_rx_en;
  assign o_rx_mid       = r_rx_mid;
  assign o_tx_en        = r_tx_en;

  // Divisor register and write handshake. An accepted write latches the new
  // divisor (and fraction) and answers with div_ack. A rejected write leaves
  // the divisor untouched and answers with div_err.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div_q   <= DIV_RST;
      r_div_ack <= 1'b0;
      r_div_err <= 1'b0;
`ifdef BAUD_FRAC_DIV_EN
      r_frac_q  <= '0;
`endif
    end else begin
      r_div_ack <= w_wr_ok;
      r_div_err <= div_if.div_wr && !w_wr_ok;
      if (w_wr_ok) begin
        r_div_q  <= div_if.div_data;
`ifdef BAUD_FRAC_DIV_EN
        r_frac_q <= div_if.div_frac;
`endif
      end
    end
  end

  // Receive prescaler. An accepted write or a restart zeroes the phase, and
  // a restart is honoured even while counting is disabled. o_rx_mid marks the
  // tick that moves the oversample count into the second half of the bit.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_wr_ok || i_rx_restart) begin
      r_rx_cnt   <= '0;
      r_rx_os    <= '0;
      r_rx_en    <= 1'b0;
      r_rx_mid   <= 1'b0;
`ifdef BAUD_FRAC_DIV_EN
      r_rx_acc   <= '0;
      r_rx_extra <= 1'b0;
`endif
    end else if (i_en) begin
      if (w_rx_hit) begin
        r_rx_cnt   <= '0;
        r_rx_os    <= w_rx_os_next;
        r_rx_en    <= 1'b1;
        r_rx_mid   <= (r_rx_os == OS_MID_M1);
`ifdef BAUD_FRAC_DIV_EN
        r_rx_acc   <= w_rx_acc_sum[3:0];
        r_rx_extra <= w_rx_acc_sum[4];
`endif
      end else begin
        r_rx_cnt   <= r_rx_cnt + DIV_ONE;
        r_rx_en    <= 1'b0;
        r_rx_mid   <= 1'b0;
      end
    end else begin
      r_rx_en  <= 1'b0;
      r_rx_mid <= 1'b0;
    end
  end

  // Transmit prescaler. This is an independent copy of the rx counters that
  // only a reset or an accepted write can realign. o_tx_en fires on the tick
  // where the oversample count wraps back to zero.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_wr_ok) begin
      r_tx_cnt   <= '0;
      r_tx_os    <= '0;
      r_tx_en    <= 1'b0;
`ifdef BAUD_FRAC_DIV_EN
      r_tx_acc   <= '0;
      r_tx_extra <= 1'b0;
`endif
    end else if (i_en) begin
      if (w_tx_hit) begin
        r_tx_cnt   <= '0;
        r_tx_os    <= w_tx_os_next;
        r_tx_en    <= (r_tx_os == OS_LAST);
`ifdef BAUD_FRAC_DIV_EN
        r_tx_acc   <= w_tx_acc_sum[3:0];
        r_tx_extra <= w_tx_acc_sum[4];
`endif
      end else begin
        r_tx_cnt   <= r_tx_cnt + DIV_ONE;
        r_tx_en    <= 1'b0;
      end
    end else begin
      r_tx_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_baud_rate_gen_param.sv
// ---------------------------------------------------------------------------
// tb_baud_rate_gen_param
//
// Purpose : self-checking bench for baud_rate_gen_param with default
//           parameters. The stimulus process drives one cycle at a time and
//           asks a reference model which pulses must appear after the next
//           edge. Each expected pulse is queued with its cycle stamp. A
//           separate monitor matches every DUT pulse against those queues.
//           The model measures periods by counting enabled cycles
//           down from div+1 (plus a fractional carry), not by counters
//           and comparators.
//
// Build option : BAUD_FRAC_DIV_EN also drives div_frac and models the
//                fractional stretch.
// ---------------------------------------------------------------------------
module tb_baud_rate_gen_param;

  localparam int OS      = 16;
  localparam int DEF_DIV = 163;
  localparam int MIN_DIV = 3;

  localparam int K_ACK = 0;
  localparam int K_ERR = 1;
  localparam int K_RX  = 2;
  localparam int K_MID = 3;
  localparam int K_TX  = 4;

  logic clk;
  logic rst;
  logic en;
  logic rxRestart;
  logic rxEn;
  logic rxMid;
  logic txEn;

  baud_rate_gen_param_if #(.DIV_W(16)) divIf ();

  baud_rate_gen_param dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_rx_restart (rxRestart),
    .div_if       (divIf),
    .o_rx_en      (rxEn),
    .o_rx_mid     (rxMid),
    .o_tx_en      (txEn)
  );

  int edgeCount = 0;
  int asserts   = 0;
  int failures  = 0;
  bit monitorOn = 0;

  int expQ [5][$];

  int mDiv;
  int mFrac;
  int rxRemain;
  int rxN;
  int txRemain;
  int txN;

  // Free-running clock and an edge counter that stamps every cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edgeCount++;

  // Number of whole clocks that tick n adds to the next period: the
  // fractional part accumulated over n ticks crosses an integer boundary.
  function automatic int carryAt(input int n, input int f);
    return ((n * f) / 16) - (((n - 1) * f) / 16);
  endfunction

  // Realign one path: first period is always div+1 with no fractional carry.
  task automatic alignRx();
    rxN      = 0;
    rxRemain = mDiv + 1;
  endtask

  task automatic alignTx();
    txN      = 0;
    txRemain = mDiv + 1;
  endtask

  // Reference model: consumes the inputs applied for the upcoming edge and
  // queues the pulses that must be visible right after it.
  task automatic modelStep(input bit r, input bit e, input bit wr,
                           input int data, input int frac, input bit rs);
    int stamp;
    stamp = edgeCount + 1;
    if (r) begin
      mDiv  = DEF_DIV;
      mFrac = 0;
      alignRx();
      alignTx();
      return;
    end
    if (wr && data >= MIN_DIV) begin
      mDiv = data;
`ifdef BAUD_FRAC_DIV_EN
      mFrac = frac;
`else
      mFrac = 0;
`endif
      alignRx();
      alignTx();
      expQ[K_ACK].push_back(stamp);
      return;
    end
    if (wr) expQ[K_ERR].push_back(stamp);
    if (rs) begin
      alignRx();
    end else if (e) begin
      rxRemain--;
      if (rxRemain == 0) begin
        rxN++;
        expQ[K_RX].push_back(stamp);
        if (rxN % OS == OS / 2) expQ[K_MID].push_back(stamp);
        rxRemain = mDiv + 1 + carryAt(rxN, mFrac);
      end
    end
    if (e) begin
      txRemain--;
      if (txRemain == 0) begin
        txN++;
        if (txN % OS == 0) expQ[K_TX].push_back(stamp);
        txRemain = mDiv + 1 + carryAt(txN, mFrac);
      end
    end
  endtask

  // Drive one cycle of inputs just after the clock edge and tell the model.
  task automatic applyStimulus(input bit r, input bit e, input bit wr,
                               input int data, input int frac, input bit rs);
    @(posedge clk);
    #1;
    rst             = r;
    en              = e;
    rxRestart       = rs;
    divIf.div_wr    = wr;
    divIf.div_data  = 16'(data);
`ifdef BAUD_FRAC_DIV_EN
    divIf.div_frac  = 4'(frac);
`endif
    modelStep(r, e, wr, data, frac, rs);
  endtask

  task automatic runCycles(input int n, input bit e);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, e, 1'b0, 0, 0, 1'b0);
  endtask

  // Match one DUT output against the front of its expectation queue.
  task automatic checkOutput(input int k, input logic pulse, input string name);
    bit due;
    due = (expQ[k].size() > 0) && (expQ[k][0] == edgeCount);
    if (pulse === 1'b1) begin
      asserts++;
      if (due) begin
        void'(expQ[k].pop_front());
      end else begin
        failures++;
        $display("[TB] FAIL %s unexpected pulse at cycle %0d: actual 1, required 0", name, edgeCount);
      end
    end else if (due) begin
      asserts++;
      failures++;
      void'(expQ[k].pop_front());
      $display("[TB] FAIL %s missing pulse at cycle %0d: actual %b, required 1", name, edgeCount, pulse);
    end
  endtask

  // Direct check that every output sits at its reset value.
  task automatic checkIdle(input string tag);
    logic [4:0] got;
    got = {divIf.div_ack, divIf.div_err, rxEn, rxMid, txEn};
    asserts++;
    if (got !== 5'b0) begin
      failures++;
      $display("[TB] FAIL %s outputs {ack,err,rx,mid,tx}: actual %b, required 00000", tag, got);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (monitorOn) begin
      checkOutput(K_ACK, divIf.div_ack, "div_ack");
      checkOutput(K_ERR, divIf.div_err, "div_err");
      checkOutput(K_RX,  rxEn,          "rx_en");
      checkOutput(K_MID, rxMid,         "rx_mid");
      checkOutput(K_TX,  txEn,          "tx_en");
    end
  end

  initial begin
    rst            = 1'b1;
    en             = 1'b0;
    rxRestart      = 1'b0;
    divIf.div_wr   = 1'b0;
    divIf.div_data = '0;
`ifdef BAUD_FRAC_DIV_EN
    divIf.div_frac = '0;
`endif
    modelStep(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkIdle("reset");
    monitorOn = 1'b1;

    $display("[TB] default divisor, free running");
    runCycles(5400, 1'b1);

    $display("[TB] rejected write, divisor 2");
    applyStimulus(1'b0, 1'b1, 1'b1, 2, 0, 1'b0);
    runCycles(400, 1'b1);

    $display("[TB] accepted write, divisor 9");
    applyStimulus(1'b0, 1'b1, 1'b1, 9, 0, 1'b0);
    runCycles(400, 1'b1);

    $display("[TB] rx restart at a random point");
    runCycles($urandom_range(1, 9), 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 1'b1);
    runCycles(200, 1'b1);

    $display("[TB] restart held high and restart while disabled");
    for (int i = 0; i < 25; i++) applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 1'b1);
    runCycles(13, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    runCycles(60, 1'b1);

    $display("[TB] enable dropped for 37 cycles mid-period");
    runCycles(4, 1'b1);
    runCycles(37, 1'b0);
    runCycles(200, 1'b1);

    $display("[TB] write and restart in the same cycle");
    applyStimulus(1'b0, 1'b1, 1'b1, 5, 0, 1'b1);
    runCycles(150, 1'b1);

`ifdef BAUD_FRAC_DIV_EN
    $display("[TB] fractional divisor 9 + 8/16");
    applyStimulus(1'b0, 1'b1, 1'b1, 9, 8, 1'b0);
    runCycles(500, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 1'b1);
    runCycles(300, 1'b1);
`endif

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'b0, ($urandom % 8) != 0, ($urandom % 211) == 0,
                    $urandom_range(0, 20), $urandom_range(0, 15),
                    ($urandom % 97) == 0);
    end

    $display("[TB] reset mid-count");
    applyStimulus(1'b0, 1'b1, 1'b1, 7, 3, 1'b0);
    runCycles(45, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    checkIdle("mid-count reset");
    runCycles(400, 1'b1);

    runCycles(3, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      asserts++;
      if (expQ[k].size() != 0) begin
        failures++;
        $display("[TB] FAIL leftover queue %0d: actual %0d pending, required 0", k, expQ[k].size());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
